i2563_event_monitor: RTL and testbench

Downstream observation stage for the `test_I2563` subcircuit: consumes its single-bit output `I2563` each qualified clock, detects the overlapping serial pattern 1-0-1-1, counts detections in a saturating counter, and compacts the sampled stream into a MISR signature. It sits directly after the upstream subcircuit in the trojan-detection benchmark harness and shares its clock and its side nets `I1908` (sample qualifier) and `I2234` (clear).

---
 rtl/i2563_event_monitor.sv | 120 ++++++++++++
 tb/tb_i2563_event_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/i2563_event_monitor.sv
// ---------------------------------------------------------------------------
// i2563_event_monitor
//
// Observation stage that sits after the test_I2563 subcircuit. Each qualified
// clock it consumes the single-bit I2563 output, looks for the overlapping
// serial pattern 1-0-1-1, counts detections in a saturating counter and
// compacts the sampled stream into a MISR signature.
//
// Ports:
//   I1294   in   1       clock, rising edge
//   I1301   in   1       asynchronous active-low reset
//   I2563   in   1       monitored data bit
//   I1908   in   1       sample enable
//   I2234   in   1       synchronous clear (wins over sample enable)
//   o_hit   out  1       one-cycle pulse after the edge that completes 1-0-1-1
//   o_count out  CNT_W   saturating hit count
//   o_sat   out  1       high while o_count is all-ones
//   o_sig   out  SIG_W   MISR signature
// ---------------------------------------------------------------------------
module i2563_event_monitor #(
   parameter int               CNT_W = 4,
   parameter int               SIG_W = 8,
   parameter logic [SIG_W-1:0] POLY  = 8'h1D
) (
   input  logic             I1294,
   input  logic             I1301,
   input  logic             I2563,
   input  logic             I1908,
   input  logic             I2234,
   output logic             o_hit,
   output logic [CNT_W-1:0] o_count,
   output logic             o_sat,
   output logic [SIG_W-1:0] o_sig
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      S1   = 2'd1,
      S10  = 2'd2,
      S101 = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CountMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CountOne = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t             state_q, state_d;
   logic               hit_q, hit_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               sat_q, sat_d;
   logic [SIG_W-1:0]   sig_q, sig_d;

   // Next-state logic. Clear beats sample, and a disabled cycle freezes the
   // matcher, counter and signature so gaps never break a partial match.
   // The hit pulse only survives one cycle because it defaults to zero here.
   always_comb begin
      state_d = state_q;
      hit_d   = 1'b0;
      count_d = count_q;
      sig_d   = sig_q;

      if (I2234) begin
         state_d = IDLE;
         count_d = '0;
         sig_d   = '0;
      end else if (I1908) begin
         // MISR step: shift out the MSB, fold it back through the taps,
         // and inject the new bit at the LSB.
         sig_d = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? POLY : {SIG_W{1'b0}})
               ^ {{(SIG_W-1){1'b0}}, I2563};

         unique case (state_q)
            IDLE: state_d = I2563 ? S1 : IDLE;
            S1:   state_d = I2563 ? S1 : S10;
            S10:  state_d = I2563 ? S101 : IDLE;
            S101: begin
               if (I2563) begin
                  // The trailing 1 of a match also starts the next one.
                  state_d = S1;
                  hit_d   = 1'b1;
               end else begin
                  state_d = S10;
               end
            end
            default: state_d = IDLE;
         endcase

         if (hit_d && (count_q != CountMax)) begin
            count_d = count_q + CountOne;
         end
      end

      // Saturation flag is derived from the next count so it is registered
      // on the same edge and always agrees with o_count.
      sat_d = (count_d == CountMax);
   end

   // State and output registers; every output comes straight from a flop.
   always_ff @(posedge I1294 or negedge I1301) begin
      if (!I1301) begin
         state_q <= IDLE;
         hit_q   <= 1'b0;
         count_q <= '0;
         sat_q   <= 1'b0;
         sig_q   <= '0;
      end else begin
         state_q <= state_d;
         hit_q   <= hit_d;
         count_q <= count_d;
         sat_q   <= sat_d;
         sig_q   <= sig_d;
      end
   end

   assign o_hit   = hit_q;
   assign o_count = count_q;
   assign o_sat   = sat_q;
   assign o_sig   = sig_q;

endmodule

// File: tb/tb_i2563_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_i2563_event_monitor
//
// Directed bench for i2563_event_monitor with default parameters. Inputs are
// driven just after a rising edge and outputs are sampled 1 time unit after
// the following rising edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_i2563_event_monitor;

   logic       clk;
   logic       rstN;
   logic       dataBit;
   logic       sampleEn;
   logic       clearEn;
   logic       hit;
   logic [3:0] count;
   logic       sat;
   logic [7:0] sig;

   int checks = 0;
   int errors = 0;

   i2563_event_monitor dut (
      .I1294   (clk),
      .I1301   (rstN),
      .I2563   (dataBit),
      .I1908   (sampleEn),
      .I2234   (clearEn),
      .o_hit   (hit),
      .o_count (count),
      .o_sat   (sat),
      .o_sig   (sig)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, then step past the next rising edge.
   task automatic applyStimulus(input logic b, input logic en, input logic clr);
      dataBit  = b;
      sampleEn = en;
      clearEn  = clr;
      @(posedge clk);
      #1;
   endtask

   // Sample a list of bits on consecutive edges without checking.
   task automatic sampleBits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         applyStimulus(bits[i], 1'b1, 1'b0);
      end
   endtask

   // Linear directed sequence.
   initial begin
      logic [7:0] expSig [4];
      logic       ovBits [7];
      logic       ovHits [7];

      rstN     = 1'b0;
      dataBit  = 1'b0;
      sampleEn = 1'b0;
      clearEn  = 1'b0;

      // Reset state
      #12;
      checkOutput("reset_hit",   hit,   0);
      checkOutput("reset_count", count, 0);
      checkOutput("reset_sat",   sat,   0);
      checkOutput("reset_sig",   sig,   0);
      #1 rstN = 1'b1;

      // MISR and single hit: 1,0,1,1
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("clear_sig", sig, 0);
      expSig = '{8'h01, 8'h02, 8'h05, 8'h0B};
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("misr_0", sig, expSig[0]);
      checkOutput("hit_early_0", hit, 0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("misr_1", sig, expSig[1]);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("misr_2", sig, expSig[2]);
      checkOutput("hit_early_2", hit, 0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("misr_3", sig, expSig[3]);
      checkOutput("single_hit", hit, 1);
      checkOutput("single_count", count, 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("single_hit_drop", hit, 0);
      checkOutput("single_count_hold", count, 1);
      checkOutput("single_sig_hold", sig, 8'h0B);

      // Overlap and gaps: 1,0,1,1,0,1,1 with two idle cycles after each bit
      applyStimulus(1'b0, 1'b0, 1'b1);
      ovBits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      ovHits = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 7; i++) begin
         applyStimulus(ovBits[i], 1'b1, 1'b0);
         checkOutput($sformatf("overlap_hit_%0d", i), hit, ovHits[i]);
         for (int g = 0; g < 2; g++) begin
            applyStimulus(~ovBits[i], 1'b0, 1'b0);
            checkOutput($sformatf("gap_hit_%0d_%0d", i, g), hit, 0);
         end
      end
      checkOutput("overlap_count", count, 2);

      // Saturation: 1 then sixteen repeats of 0,1,1 each give a hit
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int h = 1; h <= 16; h++) begin
         sampleBits(32'b011, 3);
         if (h == 14) begin
            checkOutput("sat_count_14", count, 14);
            checkOutput("sat_flag_14", sat, 0);
         end
      end
      checkOutput("sat_hit_16", hit, 1);
      checkOutput("sat_count_16", count, 15);
      checkOutput("sat_flag_16", sat, 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("sat_cleared_count", count, 0);
      checkOutput("sat_cleared_flag", sat, 0);

      // Feedback wrap: 1 then seven 0s leaves 0x80, then a 0 gives 0x1D
      sampleBits(32'b10000000, 8);
      checkOutput("wrap_preload", sig, 8'h80);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("wrap_sig", sig, 8'h1D);

      // Clear priority from S101 with a would-be completing bit
      applyStimulus(1'b0, 1'b0, 1'b1);
      sampleBits(32'b101, 3);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("clrpri_hit", hit, 0);
      checkOutput("clrpri_count", count, 0);
      checkOutput("clrpri_sig", sig, 0);
      sampleBits(32'b1011, 4);
      checkOutput("clrpri_rehit", hit, 1);
      checkOutput("clrpri_recount", count, 1);

      // Async reset while in S10 with count 3
      applyStimulus(1'b0, 1'b0, 1'b1);
      sampleBits(32'b1011011011, 10);
      checkOutput("areset_pre_count", count, 3);
      applyStimulus(1'b0, 1'b1, 1'b0);
      #3 rstN = 1'b0;
      #1;
      checkOutput("areset_hit",   hit,   0);
      checkOutput("areset_count", count, 0);
      checkOutput("areset_sat",   sat,   0);
      checkOutput("areset_sig",   sig,   0);
      #1 rstN = 1'b1;
      sampleBits(32'b011, 3);
      checkOutput("areset_nohit", hit, 0);
      checkOutput("areset_post_count", count, 0);

      // Reset while o_hit is high drops it immediately
      sampleBits(32'b011, 3);
      checkOutput("hitreset_pre", hit, 1);
      #3 rstN = 1'b0;
      #1;
      checkOutput("hitreset_hit", hit, 0);
      #1 rstN = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time limit so the bench never hangs.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

endmodule
